// File: rtl/alu_pkg.sv
// Shared encodings for the registered RV32 ALU decoder: ALUControl codes,
// ALUOp classes and the pipeline FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_MULH = 4'b1011;
  localparam logic [3:0] ALU_DIV  = 4'b1100;
  localparam logic [3:0] ALU_DIVU = 4'b1101;
  localparam logic [3:0] ALU_REM  = 4'b1110;
  localparam logic [3:0] ALU_REMU = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OUT  = 2'b01,
    MDU  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational field decode: ALUOp/funct3/funct7 bits to ALUControl plus
// illegal, multi-cycle (mul/div) and divider-class flags.
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       opb5,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic       is_mdu,
  output logic       is_div
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    is_mdu   = 1'b0;
    is_div   = 1'b0;
    case (alu_op)
      ALUOP_MEM: alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_ctrl = ALU_SUB;
          3'b100, 3'b101: alu_ctrl = ALU_SLT;
          3'b110, 3'b111: alu_ctrl = ALU_SLTU;
          default:        illegal  = 1'b1;
        endcase
      end
      ALUOP_ARITH: begin
        if (opb5 && funct7b0) begin
          if (M_EXT != 0) begin
            is_mdu = 1'b1;
            case (funct3)
              3'b000:  alu_ctrl = ALU_MUL;
              3'b100:  begin alu_ctrl = ALU_DIV;  is_div = 1'b1; end
              3'b101:  begin alu_ctrl = ALU_DIVU; is_div = 1'b1; end
              3'b110:  begin alu_ctrl = ALU_REM;  is_div = 1'b1; end
              3'b111:  begin alu_ctrl = ALU_REMU; is_div = 1'b1; end
              default: alu_ctrl = ALU_MULH;
            endcase
          end else begin
            illegal = 1'b1;
          end
        end else begin
          case (funct3)
            3'b000:  alu_ctrl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b011:  alu_ctrl = ALU_SLTU;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
          endcase
          // bit 30 only has meaning for sub and sra in R-type encodings
          if (opb5 && funct7b5 && funct3 != 3'b000 && funct3 != 3'b101)
            illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) alu_ctrl = ALU_ADD;
  end

endmodule

// File: rtl/alu_decoder_pipe.sv
// Registered ALU decoder with valid/ready handshake, flush, and a countdown
// hold for mul/div ops before their result is presented.
module alu_decoder_pipe
  import alu_pkg::*;
#(
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       opb5,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] ALUControl,
  output logic       out_illegal,
  output logic       mdu_start,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid with its data stays stable until out_ready is seen.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic       illegal_q, illegal_d;
  logic       out_valid_q, out_valid_d;
  logic       mdu_start_q, mdu_start_d;
  logic       busy_q, busy_d;

  logic [3:0] dec_ctrl;
  logic       dec_illegal, dec_is_mdu, dec_is_div;
  logic       accept;

  alu_decode_comb #(.M_EXT(M_EXT)) u_dec (
    .alu_op   (ALUOp),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .funct7b0 (funct7b0),
    .opb5     (opb5),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal),
    .is_mdu   (dec_is_mdu),
    .is_div   (dec_is_div)
  );

  assign in_ready = (state_q == IDLE) || (state_q == OUT && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_ctrl_d  = alu_ctrl_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    mdu_start_d = 1'b0;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = 4'd0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else if (accept) begin
      alu_ctrl_d = dec_ctrl;
      illegal_d  = dec_illegal;
      if (dec_is_mdu) begin
        state_d     = MDU;
        cnt_d       = dec_is_div ? DIV_CNT : MUL_CNT;
        mdu_start_d = 1'b1;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
      end else begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
      end
    end else begin
      case (state_q)
        OUT: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        MDU: begin
          if (cnt_q == 4'd0) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      alu_ctrl_q  <= ALU_ADD;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mdu_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_ctrl_q  <= alu_ctrl_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      mdu_start_q <= mdu_start_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign ALUControl  = alu_ctrl_q;
  assign out_illegal = illegal_q;
  assign mdu_start   = mdu_start_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule
